// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: request, cache data-array and main-memory signals of the line-fill engine.
interface cache_line_fill_if #(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_dirty;
    logic [ADDR_W-1:0] req_wb_addr;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  cache_word_idx;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_we;
    logic [DATA_W-1:0] cache_wdata;
    logic              mem_rden;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    modport master (
        output req_valid, req_addr, req_dirty, req_wb_addr, cache_rdata, mem_rdata, mem_valid,
        input  req_ready, busy, done, cache_word_idx, cache_we, cache_wdata,
               mem_rden, mem_wren, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_addr, req_dirty, req_wb_addr, cache_rdata, mem_rdata, mem_valid,
        output req_ready, busy, done, cache_word_idx, cache_we, cache_wdata,
               mem_rden, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_line_fill.sv
// cache_line_fill: writes back a dirty victim line, then fetches the missing line word by word.
module cache_line_fill #(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic CLK,
    input logic RST,
    cache_line_fill_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF = IDX_W + 2;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;
    state_t state, state_next;
    logic [IDX_W-1:0] cnt, cnt_next;
    logic [ADDR_W-1:0] fill_base, wb_base, word_off;
    logic accept, last;
    assign word_off = ADDR_W'({cnt, 2'b00});
    assign last = cnt == IDX_W'(WORDS_PER_LINE - 1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_base <= '0;
            wb_base   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                fill_base <= {bus.req_addr[ADDR_W-1:OFF], OFF'(0)};
                wb_base   <= {bus.req_wb_addr[ADDR_W-1:OFF], OFF'(0)};
            end
        end
    end
    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        accept             = 1'b0;
        bus.req_ready      = 1'b0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.cache_word_idx = '0;
        bus.cache_we       = 1'b0;
        bus.cache_wdata    = '0;
        bus.mem_rden       = 1'b0;
        bus.mem_wren       = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (accept) begin
                    cnt_next   = '0;
                    state_next = bus.req_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.busy           = 1'b1;
                bus.mem_wren       = 1'b1;
                bus.mem_addr       = wb_base + word_off;
                bus.cache_word_idx = cnt;
                bus.mem_wdata      = bus.cache_rdata;
                if (bus.mem_valid) begin
                    cnt_next   = cnt + 1'b1;
                    state_next = last ? FILL : WRITEBACK;
                end
            end
            FILL: begin
                bus.busy           = 1'b1;
                bus.mem_rden       = 1'b1;
                bus.mem_addr       = fill_base + word_off;
                bus.cache_word_idx = cnt;
                bus.cache_we       = bus.mem_valid;
                bus.cache_wdata    = bus.mem_rdata;
                if (bus.mem_valid) begin
                    cnt_next   = cnt + 1'b1;
                    state_next = last ? DONE : FILL;
                end
            end
            default: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: randomized scenarios checked against a queue of expected memory beats.
module tb_cache_line_fill;
    localparam int W = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(W);
    localparam int VW = 5 + AW + DW + IW + 1 + DW;
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } beat_t;
    logic CLK = 1'b0;
    logic RST;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] victim [W];
    always #5 CLK = ~CLK;
    cache_line_fill_if #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) bus ();
    cache_line_fill #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    assign bus.cache_rdata = victim[bus.cache_word_idx];

    // Flag summary: {req_ready, busy, done, mem_rden, mem_wren, cache_we}
    function automatic logic [5:0] flags();
        return {bus.req_ready, bus.busy, bus.done, bus.mem_rden, bus.mem_wren, bus.cache_we};
    endfunction

    task automatic run_xfer(input string name, input logic [AW-1:0] addr, input logic [AW-1:0] wb,
                            input logic dirty, input int period, input bit fixed_rdata,
                            input int glitch, output int done_cyc, output int n_we);
        beat_t q[$];
        int bi;
        logic [AW-1:0] fb, wbb;
        logic [DW-1:0] rd;
        logic [VW-1:0] obs, exp;
        logic exp_we;
        fb  = addr & ~AW'(W * 4 - 1);
        wbb = wb & ~AW'(W * 4 - 1);
        if (dirty) for (int k = 0; k < W; k++) q.push_back('{1'b1, wbb + AW'(4 * k), victim[k], IW'(k)});
        for (int k = 0; k < W; k++) q.push_back('{1'b0, fb + AW'(4 * k), '0, IW'(k)});
        done_cyc = -1;
        n_we = 0;
        bi = 0;
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        bus.req_wb_addr = wb;
        bus.req_dirty = dirty;
        bus.mem_valid = 1'b0;
        #1;
        checks++;
        if (flags() !== 6'b100000) begin
            failures++;
            $display("FAIL %s accept: flags=%b expected=%b", name, flags(), 6'b100000);
        end
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            bus.req_valid = (cyc == glitch);
            bus.req_addr = $urandom;
            bus.req_wb_addr = $urandom;
            bus.req_dirty = 1'($urandom);
            bus.mem_valid = (period == 0) ? 1'($urandom_range(0, 1)) : (cyc % period == 0);
            rd = (fixed_rdata && bi < q.size()) ? DW'(32'hA0 + q[bi].idx) : DW'($urandom);
            bus.mem_rdata = rd;
            #1;
            if (bi < q.size()) begin
                exp_we = bus.mem_valid && !q[bi].wr;
                exp = {1'b0, 1'b1, 1'b0, !q[bi].wr, q[bi].wr, q[bi].addr,
                       q[bi].wr ? q[bi].data : DW'(0), q[bi].idx, exp_we, exp_we ? rd : DW'(0)};
                obs = {bus.req_ready, bus.busy, bus.done, bus.mem_rden, bus.mem_wren, bus.mem_addr,
                       q[bi].wr ? bus.mem_wdata : DW'(0), bus.cache_word_idx, bus.cache_we,
                       bus.cache_we ? bus.cache_wdata : DW'(0)};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL %s beat%0d cyc%0d: got=%h expected=%h", name, bi, cyc, obs, exp);
                end
                if (bus.cache_we) n_we++;
                if (bus.mem_valid) bi++;
            end else begin
                checks++;
                if (flags() !== 6'b011000) begin
                    failures++;
                    $display("FAIL %s done_cycle cyc%0d: flags=%b expected=%b", name, cyc, flags(), 6'b011000);
                end
                done_cyc = cyc;
            end
        end
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s timeout: beats=%0d expected=%0d", name, bi, q.size());
        end else begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            bus.mem_valid = 1'($urandom);
            #1;
            if (flags() !== 6'b100000) begin
                failures++;
                $display("FAIL %s back_to_idle: flags=%b expected=%b", name, flags(), 6'b100000);
            end
        end
        bus.req_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_wb_addr = '0;
        bus.req_dirty = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        for (int k = 0; k < W; k++) victim[k] = DW'(32'hD0 + k);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (flags() !== 6'b100000 || bus.mem_addr !== '0 || bus.cache_word_idx !== '0) begin
            failures++;
            $display("FAIL reset: flags=%b addr=%h idx=%0d expected flags=100000 addr=0 idx=0",
                     flags(), bus.mem_addr, bus.cache_word_idx);
        end
    endtask

    task automatic test_clean_fill();
        int dc, nw;
        run_xfer("clean", 32'h0000_1234, 32'h0, 1'b0, 1, 1'b1, -1, dc, nw);
        checks++;
        if (dc !== 9 || nw !== 8) begin
            failures++;
            $display("FAIL clean_latency: done_cyc=%0d writes=%0d expected 9 and 8", dc, nw);
        end
    endtask

    task automatic test_dirty_fill();
        int dc, nw;
        run_xfer("dirty", 32'h0000_2040, 32'h0000_8000, 1'b1, 1, 1'b1, -1, dc, nw);
        checks++;
        if (dc !== 17 || nw !== 8) begin
            failures++;
            $display("FAIL dirty_latency: done_cyc=%0d writes=%0d expected 17 and 8", dc, nw);
        end
    endtask

    task automatic test_wait_states();
        int dc, nw;
        run_xfer("wait3", 32'h0001_00FC, 32'h0, 1'b0, 3, 1'b0, -1, dc, nw);
        checks++;
        if (dc !== 25 || nw !== 8) begin
            failures++;
            $display("FAIL wait3_latency: done_cyc=%0d writes=%0d expected 25 and 8", dc, nw);
        end
    endtask

    task automatic test_reset_mid_fill();
        int dc, nw;
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0000_4400;
        bus.req_dirty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            bus.req_valid = 1'b0;
            bus.mem_valid = 1'b1;
            #1;
            checks++;
            if (bus.cache_we !== 1'b1 || bus.cache_word_idx !== IW'(k) || bus.mem_addr !== 32'h4400 + 4 * k) begin
                failures++;
                $display("FAIL rst_pre word%0d: we=%b idx=%0d addr=%h expected 1 %0d %h",
                         k, bus.cache_we, bus.cache_word_idx, bus.mem_addr, k, 32'h4400 + 4 * k);
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        bus.mem_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            RST = 1'b0;
            bus.mem_valid = 1'b1;
            #1;
            checks++;
            if (flags() !== 6'b100000) begin
                failures++;
                $display("FAIL rst_after cyc%0d: flags=%b expected=%b", k, flags(), 6'b100000);
            end
        end
        bus.mem_valid = 1'b0;
        run_xfer("post_rst", 32'h0000_5510, 32'h0, 1'b0, 1, 1'b0, -1, dc, nw);
    endtask

    task automatic test_req_during_fill();
        int dc, nw;
        run_xfer("glitch", 32'h0000_6000, 32'h0000_7000, 1'b0, 1, 1'b0, 3, dc, nw);
        checks++;
        if (dc !== 9 || nw !== 8) begin
            failures++;
            $display("FAIL glitch_done: done_cyc=%0d writes=%0d expected 9 and 8", dc, nw);
        end
    endtask

    task automatic test_idle_valid();
        int dc, nw;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            bus.mem_valid = 1'b1;
            bus.mem_rdata = $urandom;
            #1;
            checks++;
            if (flags() !== 6'b100000) begin
                failures++;
                $display("FAIL idle_valid cyc%0d: flags=%b expected=%b", k, flags(), 6'b100000);
            end
        end
        run_xfer("idle_valid", 32'h0000_9008, 32'h0, 1'b0, 1, 1'b0, -1, dc, nw);
        run_xfer("after_done", 32'h0000_A018, 32'h0000_B000, 1'b1, 1, 1'b0, -1, dc, nw);
    endtask

    task automatic test_random();
        int dc, nw;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < W; k++) victim[k] = $urandom;
            run_xfer("random", $urandom, $urandom, 1'($urandom), (t % 2 == 0) ? 0 : 2, 1'b0, -1, dc, nw);
            checks++;
            if (nw !== 8) begin
                failures++;
                $display("FAIL random_writes t%0d: writes=%0d expected=8", t, nw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_fill();
        test_dirty_fill();
        test_wait_states();
        test_reset_mid_fill();
        test_req_during_fill();
        test_idle_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
